regfile_wb_scheduler: RTL and testbench

- Shares the single write port of the 16x16 register file between NUM_REQ writeback sources (e.g. ALU, load unit, move/immediate path) using round-robin arbitration.
- Keeps a 16-bit busy scoreboard so the issue stage can reserve destination registers and detect read-after-write hazards on the two read addresses.
- Sits between the execute/writeback units and the register file write inputs (writeAddr/writeEn/dataWrite).

---
 rtl/regfile_wb_scheduler.sv | 96 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the register file write port, with a busy scoreboard
// so the issue stage can reserve destinations and check read operands for hazards.
module regfile_wb_scheduler #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic                             rsv_valid,
   input  logic [ADDR_WIDTH-1:0]            rsv_addr,
   output logic                             rsv_ok,
   input  logic [ADDR_WIDTH-1:0]            chk_addrA,
   input  logic [ADDR_WIDTH-1:0]            chk_addrB,
   output logic                             busyA,
   output logic                             busyB,
   output logic [(2**ADDR_WIDTH)-1:0]       busy_vec,
   output logic [ADDR_WIDTH-1:0]            writeAddr,
   output logic                             writeEn,
   output logic [DATA_WIDTH-1:0]            dataWrite
);
   localparam int NREG = 2**ADDR_WIDTH;
   localparam int PW   = $clog2(NUM_REQ);

   logic [PW-1:0]         rr_ptr_q, rr_ptr_d, gnt_idx;
   logic                  found;
   logic [NUM_REQ-1:0]    grant;
   logic [NREG-1:0]       busy_q, busy_d, clr_mask, set_mask;
   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   // Scan requesters starting at the pointer; first valid one wins.
   always_comb begin
      int idx;
      idx     = 0;
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gnt_idx    = PW'(idx);
         end
      end
   end

   assign req_ready = grant;
   assign rsv_ok    = rsv_valid && !busy_q[rsv_addr];
   assign busyA     = busy_q[chk_addrA];
   assign busyB     = busy_q[chk_addrB];
   assign busy_vec  = busy_q;
   assign writeEn   = wen_q;
   assign writeAddr = waddr_q;
   assign dataWrite = wdata_q;

   // Clear lands on the same edge the register file commits, so a same-cycle
   // reservation still sees the register busy and is refused.
   assign clr_mask = wen_q  ? (NREG'(1) << waddr_q)  : '0;
   assign set_mask = rsv_ok ? (NREG'(1) << rsv_addr) : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      wen_d    = found;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      busy_d   = (busy_q & ~clr_mask) | set_mask;
      if (found) begin
         rr_ptr_d = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
         waddr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
         wdata_d  = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         busy_q   <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and random checks of regfile_wb_scheduler against a cycle-level
// reference model of the arbitration and scoreboard rules.
module tb_regfile_wb_scheduler;
   localparam int N  = 3;
   localparam int DW = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic [N-1:0]       rv;
   logic [N*AW-1:0]    ra;
   logic [N*DW-1:0]    rd;
   logic [N-1:0]       req_ready;
   logic               rsv_v, rsv_ok;
   logic [AW-1:0]      rsv_a, ca, cb;
   logic               busyA, busyB;
   logic [15:0]        busy_vec;
   logic [AW-1:0]      writeAddr;
   logic               writeEn;
   logic [DW-1:0]      dataWrite;

   regfile_wb_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(rst),
      .req_valid(rv), .req_addr(ra), .req_data(rd), .req_ready(req_ready),
      .rsv_valid(rsv_v), .rsv_addr(rsv_a), .rsv_ok(rsv_ok),
      .chk_addrA(ca), .chk_addrB(cb), .busyA(busyA), .busyB(busyB),
      .busy_vec(busy_vec), .writeAddr(writeAddr), .writeEn(writeEn),
      .dataWrite(dataWrite)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int        m_ptr;
   bit [15:0] m_busy;
   bit        m_wen;
   bit [3:0]  m_waddr;
   bit [15:0] m_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input bit v, input bit [3:0] a, input bit [15:0] d);
      rv[i]          = v;
      ra[i*AW +: AW] = a;
      rd[i*DW +: DW] = d;
   endtask

   // Check all outputs against the model, advance one clock, update the model.
   task automatic cycle(input bit do_chk);
      int        g;
      bit [2:0]  exp_rdy;
      bit        exp_ok;
      #1;
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      exp_ok  = rsv_v && !m_busy[rsv_a];
      if (do_chk) begin
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("rsv_ok",    32'(rsv_ok),    32'(exp_ok));
         chk("busyA",     32'(busyA),     32'(m_busy[ca]));
         chk("busyB",     32'(busyB),     32'(m_busy[cb]));
         chk("busy_vec",  32'(busy_vec),  32'(m_busy));
         chk("writeEn",   32'(writeEn),   32'(m_wen));
         if (m_wen) begin
            chk("writeAddr", 32'(writeAddr), 32'(m_waddr));
            chk("dataWrite", 32'(dataWrite), 32'(m_wdata));
         end
      end
      if (rst) begin
         m_ptr = 0; m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
      end else begin
         if (m_wen) m_busy[m_waddr] = 1'b0;
         if (exp_ok) m_busy[rsv_a] = 1'b1;
         m_wen = (g >= 0);
         if (g >= 0) begin
            m_waddr = ra[g*AW +: AW];
            m_wdata = rd[g*DW +: DW];
            m_ptr   = (g + 1) % N;
         end
      end
      @(posedge clk);
      #1;
   endtask

   logic [2:0] gseq [6];

   initial begin
      m_ptr = 0; m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
      rst = 1'b1; rv = '1; ra = '0; rd = '0;
      rsv_v = 1'b1; rsv_a = 4'd3; ca = '0; cb = '0;
      @(posedge clk); #1;
      cycle(1'b0);
      // reset held with every request and a reservation pending
      #1;
      chk("rst_ready",   32'(req_ready), 32'h1);
      chk("rst_writeEn", 32'(writeEn),   32'h0);
      chk("rst_busy",    32'(busy_vec),  32'h0);
      cycle(1'b1);

      // round robin over three always-valid requesters
      rst = 1'b0; rsv_v = 1'b0;
      set_req(0, 1, 4'd1, 16'hA001);
      set_req(1, 1, 4'd2, 16'hA002);
      set_req(2, 1, 4'd3, 16'hA003);
      gseq[0] = 3'b001; gseq[1] = 3'b010; gseq[2] = 3'b100;
      gseq[3] = 3'b001; gseq[4] = 3'b010; gseq[5] = 3'b100;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_grant", 32'(req_ready), 32'(gseq[i]));
         cycle(1'b1);
         chk("rr_waddr", 32'(writeAddr), 32'((i % 3) + 1));
         chk("rr_wen",   32'(writeEn),   32'h1);
      end

      // sparse: move pointer to 2, then only requester 1 valid
      rv = 3'b010;
      cycle(1'b1);
      #1;
      chk("sparse_grant", 32'(req_ready), 32'h2);
      cycle(1'b1);
      rv = 3'b101;
      #1;
      chk("wrap_grant", 32'(req_ready), 32'h4);
      cycle(1'b1);

      // scoreboard reserve, double reserve, write-back clear
      rv = '0; rsv_v = 1'b1; rsv_a = 4'd5; ca = 4'd5; cb = 4'd2;
      #1;
      chk("rsv5_ok", 32'(rsv_ok), 32'h1);
      cycle(1'b1);
      chk("rsv5_busy", 32'(busy_vec[5]), 32'h1);
      chk("rsv5_dup",  32'(rsv_ok),      32'h0);
      chk("busyA_5",   32'(busyA),       32'h1);
      cycle(1'b1);
      rsv_v = 1'b0;
      set_req(1, 1, 4'd5, 16'hBEEF);
      cycle(1'b1);
      rv = '0;
      chk("beef_wen",  32'(writeEn),   32'h1);
      chk("beef_data", 32'(dataWrite), 32'hBEEF);
      chk("beef_busyA_still", 32'(busyA), 32'h1);
      cycle(1'b1);
      chk("beef_busyA_clr", 32'(busyA), 32'h0);
      cycle(1'b1);

      // clear/reserve collision on r7
      rsv_v = 1'b1; rsv_a = 4'd7; ca = 4'd7;
      cycle(1'b1);
      rsv_v = 1'b0;
      set_req(0, 1, 4'd7, 16'h0777);
      cycle(1'b1);
      rv = '0; rsv_v = 1'b1;
      chk("coll_wen",  32'(writeEn),   32'h1);
      chk("coll_addr", 32'(writeAddr), 32'h7);
      chk("coll_ok",   32'(rsv_ok),    32'h0);
      cycle(1'b1);
      chk("coll_cleared", 32'(busy_vec[7]), 32'h0);
      chk("coll_retry",   32'(rsv_ok),      32'h1);
      cycle(1'b1);
      rsv_v = 1'b0;
      cycle(1'b1);

      // reset in the middle of a write-back to r9
      rsv_v = 1'b1; rsv_a = 4'd9;
      cycle(1'b1);
      rsv_v = 1'b0;
      set_req(1, 1, 4'd9, 16'h9999); rv[0] = 1'b0; rv[2] = 1'b0;
      cycle(1'b1);
      rst = 1'b1; rv = 3'b111; rsv_v = 1'b1; rsv_a = 4'd4;
      cycle(1'b1);
      rst = 1'b0; rv = 3'b111; rsv_v = 1'b0;
      #1;
      chk("mid_rst_busy",  32'(busy_vec),  32'h0);
      chk("mid_rst_wen",   32'(writeEn),   32'h0);
      chk("mid_rst_ptr",   32'(req_ready), 32'h1);
      cycle(1'b1);

      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         rst   = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < N; i++)
            set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
         rsv_v = 1'($urandom_range(0, 1));
         rsv_a = 4'($urandom_range(0, 15));
         ca    = 4'($urandom_range(0, 15));
         cb    = 4'($urandom_range(0, 15));
         cycle(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
